g_penc8r: RTL and testbench

G_PENC8R -- requirements
Module: g_penc8r

---
 rtl/g_macro_pkg.sv | 21 ++
 rtl/g_penc8r_if.sv | 37 +++
 rtl/g_penc8.sv | 27 ++
 rtl/g_penc8r.sv | 67 ++++++
 tb/tb_g_penc8r.sv | 183 ++++++++++++++++++
 5 files changed

// File: rtl/g_macro_pkg.sv
// Shared constants and types for the g_penc8r registered priority encoder.
// The stored word is {NONE, Q}; the output buffer is two words deep.
package g_macro_pkg;

    localparam int WORD_W = 4;
    localparam int DEPTH  = 2;
    localparam int CNT_W  = 2;

    // Count value at which the buffer is full and stops accepting samples.
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    // One buffered result: none flag in the MSB, encoded index below it.
    typedef struct packed {
        logic       none;
        logic [2:0] q;
    } word_t;

    // Word shown on the outputs straight after reset: no line, index 0.
    localparam word_t EMPTY_WORD = '{none: 1'b1, q: 3'b000};

endpackage

// File: rtl/g_penc8r_if.sv
// Sample-in / result-out handshake bundle for g_penc8r.
// Handshake: a word moves on a rising edge only when its valid (STB upstream,
// OV downstream) and its ready (RDY upstream, ORDY downstream) are both 1.
// RDY depends only on the buffer fill level, never on STB or ORDY.
interface g_penc8r_if;

    logic [7:0] DN;
    logic       STB;
    logic       RDY;
    logic [2:0] Q;
    logic       NONE;
    logic       OV;
    logic       ORDY;

    // Block side: takes samples, presents encoded results.
    modport slave (
        input  DN,
        input  STB,
        input  ORDY,
        output RDY,
        output Q,
        output NONE,
        output OV
    );

    // Environment side: drives samples and downstream ready.
    modport master (
        output DN,
        output STB,
        output ORDY,
        input  RDY,
        input  Q,
        input  NONE,
        input  OV
    );

endinterface

// File: rtl/g_penc8.sv
// Combinational 8-to-3 priority encoder; line 7 has the highest priority.
// INV=1 treats a 0 on a request line as asserted.
module g_penc8 #(
    parameter int unsigned INV = 1
) (
    input  logic [7:0] dn,
    output logic [2:0] q,
    output logic       none
);

    logic [7:0] act;

    assign act = (INV != 0) ? ~dn : dn;

    // Scan upward so the highest asserted line is the last one to win.
    always_comb begin
        q    = 3'b000;
        none = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if (act[i]) begin
                q    = 3'(i);
                none = 1'b0;
            end
        end
    end

endmodule

// File: rtl/g_penc8r.sv
// Registered priority encoder: each accepted sample is encoded and queued in a
// two-entry in-order buffer; the head entry drives Q/NONE while OV is high.
module g_penc8r
    import g_macro_pkg::*;
#(
    parameter int unsigned INV = 1
) (
    input  logic      CLK,
    input  logic      RST,
    g_penc8r_if.slave bus
);

    logic             enc_q_none;
    logic [2:0]       enc_q;
    word_t            enc_word;
    word_t            mem [DEPTH];
    logic [CNT_W-1:0] count;
    logic             wr_ptr;
    logic             rd_ptr;
    logic             push;
    logic             pop;

    g_penc8 #(
        .INV (INV)
    ) u_enc (
        .dn   (bus.DN),
        .q    (enc_q),
        .none (enc_q_none)
    );

    assign enc_word = '{none: enc_q_none, q: enc_q};

    // Ready and valid are decodes of the registered fill level only.
    assign bus.RDY  = (count != CNT_FULL);
    assign bus.OV   = (count != '0);
    assign bus.Q    = mem[rd_ptr].q;
    assign bus.NONE = mem[rd_ptr].none;

    assign push = bus.STB & bus.RDY;
    assign pop  = bus.OV & bus.ORDY;

    // Buffer storage, pointers and fill count; reset flushes every entry.
    always_ff @(posedge CLK) begin
        if (RST) begin
            count  <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= EMPTY_WORD;
            end
        end else begin
            if (push) begin
                mem[wr_ptr] <= enc_word;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_g_penc8r.sv
// Directed and random bench for g_penc8r with a queue-based scoreboard.
module tb_g_penc8r;

    logic clk = 1'b0;
    logic rst;

    g_penc8r_if a ();
    g_penc8r_if b ();

    g_penc8r #(.INV(1)) dut (
        .CLK (clk),
        .RST (rst),
        .bus (a.slave)
    );

    g_penc8r #(.INV(0)) dut0 (
        .CLK (clk),
        .RST (rst),
        .bus (b.slave)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [3:0] exp_q[$];
    int         m_cnt      = 0;
    bit         m_rst      = 1'b1;
    bit         hold_valid = 1'b0;
    logic [3:0] hold_word  = 4'b0000;

    // Reference encoder: search downward from line 7, {none, q} result.
    function automatic logic [3:0] ref_enc(input logic [7:0] dn, input bit inv);
        logic [7:0] act;
        act = inv ? ~dn : dn;
        for (int i = 7; i >= 0; i--) begin
            if (act[i]) return {1'b0, 3'(i)};
        end
        return 4'b1000;
    endfunction

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: drive at negedge, check current outputs, advance the model.
    task automatic cycle(input logic r, input logic [7:0] dn, input logic stb, input logic ordy);
        bit do_push;
        bit do_pop;
        @(negedge clk);
        rst    = r;
        a.DN   = dn;
        a.STB  = stb;
        a.ORDY = ordy;
        #1;
        check("rdy", {3'b000, a.RDY}, {3'b000, (m_cnt != 2)});
        check("ov", {3'b000, a.OV}, {3'b000, (m_cnt != 0)});
        if (m_cnt != 0) check("head", {a.NONE, a.Q}, exp_q[0]);
        if (m_rst) check("rst_word", {a.NONE, a.Q}, 4'b1000);
        if (hold_valid) check("hold", {a.NONE, a.Q}, hold_word);
        hold_valid = 1'b0;
        if (!r && m_cnt > 0 && !ordy) begin
            hold_valid = 1'b1;
            hold_word  = exp_q[0];
        end
        if (r) begin
            exp_q.delete();
            m_cnt = 0;
            m_rst = 1'b1;
        end else begin
            do_push = stb && (m_cnt < 2);
            do_pop  = ordy && (m_cnt > 0);
            if (do_pop) void'(exp_q.pop_front());
            if (do_push) exp_q.push_back(ref_enc(dn, 1'b1));
            m_cnt = exp_q.size();
            m_rst = 1'b0;
        end
    endtask

    // Check outputs right after the edge modelled by the previous cycle call.
    task automatic expect_now(input string tag, input logic ov, input logic rdy,
                              input logic [3:0] word, input bit chk_word);
        @(posedge clk);
        #1;
        check({tag, "_ov"}, {3'b000, a.OV}, {3'b000, ov});
        check({tag, "_rdy"}, {3'b000, a.RDY}, {3'b000, rdy});
        if (chk_word) check({tag, "_word"}, {a.NONE, a.Q}, word);
    endtask

    initial begin
        rst    = 1'b1;
        a.DN   = 8'h00;
        a.STB  = 1'b0;
        a.ORDY = 1'b0;
        b.DN   = 8'h00;
        b.STB  = 1'b0;
        b.ORDY = 1'b1;
        repeat (2) @(posedge clk);

        // Reset state of the active-high instance, then one push into it.
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("b_rst_ov", {3'b000, b.OV}, 4'b0000);
        check("b_rst_rdy", {3'b000, b.RDY}, 4'b0001);
        check("b_rst_word", {b.NONE, b.Q}, 4'b1000);
        b.DN  = 8'h81;
        b.STB = 1'b1;
        @(posedge clk);
        #1;
        check("b_enc_ov", {3'b000, b.OV}, 4'b0001);
        check("b_enc_word", {b.NONE, b.Q}, 4'b0111);
        @(negedge clk);
        b.STB = 1'b0;
        @(posedge clk);
        #1;
        check("b_drain_ov", {3'b000, b.OV}, 4'b0000);

        // Reset state of the main instance.
        cycle(1'b0, 8'h00, 1'b0, 1'b0);

        // Basic encode with active-low lines: ~1110_1011 -> line 4.
        cycle(1'b0, 8'b1110_1011, 1'b1, 1'b1);
        expect_now("enc", 1'b1, 1'b1, 4'b0100, 1'b1);
        cycle(1'b0, 8'h00, 1'b0, 1'b1);
        expect_now("enc_pop", 1'b0, 1'b1, 4'b0000, 1'b0);

        // No asserted line.
        cycle(1'b0, 8'hFF, 1'b1, 1'b1);
        expect_now("none", 1'b1, 1'b1, 4'b1000, 1'b1);
        cycle(1'b0, 8'h00, 1'b0, 1'b1);

        // Backpressure: fill with Q=3 then Q=5, third strobe is dropped.
        cycle(1'b0, 8'hF4, 1'b1, 1'b0);
        cycle(1'b0, 8'hD9, 1'b1, 1'b0);
        expect_now("full", 1'b1, 1'b0, 4'b0011, 1'b1);
        cycle(1'b0, 8'h00, 1'b1, 1'b0);
        cycle(1'b0, 8'h00, 1'b0, 1'b1);
        expect_now("pop1", 1'b1, 1'b1, 4'b0101, 1'b1);
        cycle(1'b0, 8'h00, 1'b0, 1'b1);
        expect_now("pop2", 1'b0, 1'b1, 4'b0000, 1'b0);
        cycle(1'b0, 8'h00, 1'b0, 1'b0);

        // Push and pop together at count 1: output advances, count stays 1.
        cycle(1'b0, 8'hF4, 1'b1, 1'b0);
        cycle(1'b0, 8'hD9, 1'b1, 1'b1);
        expect_now("pushpop", 1'b1, 1'b1, 4'b0101, 1'b1);
        cycle(1'b0, 8'h00, 1'b0, 1'b1);

        // Sustained streaming: one word per cycle with RDY held high.
        for (int i = 0; i < 16; i++) begin
            cycle(1'b0, 8'($urandom_range(0, 255)), 1'b1, 1'b1);
        end
        cycle(1'b0, 8'h00, 1'b0, 1'b1);

        // Reset with a full buffer; only the next push may appear afterwards.
        cycle(1'b0, 8'h7F, 1'b1, 1'b0);
        cycle(1'b0, 8'hBF, 1'b1, 1'b0);
        cycle(1'b1, 8'h00, 1'b1, 1'b1);
        expect_now("midrst", 1'b0, 1'b1, 4'b1000, 1'b1);
        cycle(1'b0, 8'hEF, 1'b1, 1'b0);
        expect_now("post_rst", 1'b1, 1'b1, 4'b0100, 1'b1);
        cycle(1'b0, 8'h00, 1'b0, 1'b1);
        expect_now("post_rst_pop", 1'b0, 1'b1, 4'b0000, 1'b0);

        // Random strobe/ready traffic.
        for (int i = 0; i < 10000; i++) begin
            cycle(1'b0, 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 3) != 0));
        end
        repeat (4) cycle(1'b0, 8'h00, 1'b0, 1'b1);
        cycle(1'b0, 8'h00, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
